// File: rtl/multibyte_add_seq.sv
// Sequential NBYTES-wide adder driving an external 8-bit ripple-carry adder one byte per cycle.
// Optional macro SUB_MODE_EN adds the sub port and two's-complement A-B mode.
module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  cin_in,
`ifdef SUB_MODE_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  overflow,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_s,
    input  logic                  add_car
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_opa;
    logic [W-1:0]  r_opb;
    logic [W-1:0]  r_sum;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic          r_cout;
    logic          r_ovf;
    logic          w_sub;
    logic [W-1:0]  w_opb_in;
    logic          w_carry_in;
    logic          w_last;
    logic          w_ovf;

`ifdef SUB_MODE_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // A + ~B + 1 yields A - B; the external cin_in has no meaning in that mode.
    assign w_opb_in   = w_sub ? ~op_b : op_b;
    assign w_carry_in = w_sub ? 1'b1 : cin_in;
    assign w_last     = (r_idx == LAST_IDX);
    assign w_ovf      = add_a[7] ^ add_b[7] ^ add_s[7] ^ add_car;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        add_a       = '0;
        add_b       = '0;
        add_cin     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                add_a   = r_opa[{r_idx, 3'b000} +: 8];
                add_b   = r_opb[{r_idx, 3'b000} +: 8];
                add_cin = r_carry;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opa   <= op_a;
                        r_opb   <= w_opb_in;
                        r_carry <= w_carry_in;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum[{r_idx, 3'b000} +: 8] <= add_s;
                    r_carry                     <= add_car;
                    r_idx                       <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout <= add_car;
                        r_ovf  <= w_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq: a whole-word arithmetic model checked every cycle,
// plus directed operations with hand-computed results.
module tb_multibyte_add_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic         start  = 1'b0;
    logic         cin_in = 1'b0;
    logic         sub    = 1'b0;
    logic [W-1:0] op_a   = '0;
    logic [W-1:0] op_b   = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_s;
    logic         add_car;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // External 8-bit adder the controller drives.
    assign {add_car, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin_in   (cin_in),
`ifdef SUB_MODE_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_car  (add_car)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W:0] low_bytes(input logic [W:0] v, input int k);
        logic [W:0] mask;
        mask = '1;
        mask = mask >> (W + 1 - 8 * k);
        return v & mask;
    endfunction

    // Model: m_cnt is -1 when idle, else the number of edges since the accepting edge.
    int           m_cnt  = -1;
    bit           m_live = 1'b0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;
    logic [W-1:0] m_sum  = '0;
    logic [W:0]   m_full = '0;
    logic         m_c0   = 1'b0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1;
            m_cnt  = -1;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_cnt < 0) begin
            if (start) begin
                m_a    = op_a;
                m_b    = sub ? ~op_b : op_b;
                m_c0   = sub ? 1'b1 : cin_in;
                m_full = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_c0};
                m_sum  = '0;
                m_cnt  = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt <= NB) m_sum = W'(low_bytes(m_full, m_cnt));
            if (m_cnt == NB) begin
                m_cout = m_full[W];
                m_ovf  = (m_a[W-1] == m_b[W-1]) && (m_full[W-1] != m_a[W-1]);
            end
            if (m_cnt > NB) m_cnt = -1;
        end
    end

    always @(negedge clk) begin
        logic [W:0] part;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ec;
        if (m_live) begin
            ea = '0;
            eb = '0;
            ec = 1'b0;
            if (m_cnt >= 0 && m_cnt < NB) begin
                ea   = m_a[8*m_cnt +: 8];
                eb   = m_b[8*m_cnt +: 8];
                part = low_bytes({1'b0, m_a}, m_cnt) + low_bytes({1'b0, m_b}, m_cnt)
                       + {{W{1'b0}}, m_c0};
                ec   = part[8*m_cnt];
            end
            check("model busy",     64'(busy),     64'(m_cnt >= 0));
            check("model done",     64'(done),     64'(m_cnt == NB));
            check("model add_a",    64'(add_a),    64'(ea));
            check("model add_b",    64'(add_b),    64'(eb));
            check("model add_cin",  64'(add_cin),  64'(ec));
            check("model sum",      64'(sum),      64'(m_sum));
            check("model cout",     64'(cout),     64'(m_cout));
            check("model overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    logic [7:0] a_seen [NB];

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                            input logic s);
        @(negedge clk);
        op_a   = a;
        op_b   = b;
        cin_in = c;
        sub    = s;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Entered at the negedge of cycle n0 after the accepting edge; done must appear in cycle NB.
    task automatic wait_done(input string tag, input int n0);
        int n;
        n = n0;
        while (n < 20) begin
            if (n < NB) a_seen[n] = add_a;
            if (done) break;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(NB));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s, input logic [W-1:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        start_op(a, b, c, s);
        wait_done(tag, 0);
        check({tag, " sum"},      64'(sum),      64'(exp_sum));
        check({tag, " cout"},     64'(cout),     64'(exp_cout));
        check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(done), 64'(0));
        check({tag, " idle"},           64'(busy), 64'(0));
    endtask

    initial begin
        int n_done;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy",     64'(busy),     64'(0));
        check("reset done",     64'(done),     64'(0));
        check("reset sum",      64'(sum),      64'(0));
        check("reset cout",     64'(cout),     64'(0));
        check("reset overflow", 64'(overflow), 64'(0));
        check("reset add_a",    64'(add_a),    64'(0));
        rst = 1'b0;

        run_op("carry chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("signed ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("cin add",     32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
        check("add_a byte0", 64'(a_seen[0]), 64'(8'h78));
        check("add_a byte1", 64'(a_seen[1]), 64'(8'h56));
        check("add_a byte2", 64'(a_seen[2]), 64'(8'h34));
        check("add_a byte3", 64'(a_seen[3]), 64'(8'h12));

        // A start pulsed mid-run with other operands must be ignored.
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clk);
        op_a   = 32'hAAAA_AAAA;
        op_b   = 32'h5555_5555;
        cin_in = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done("start in run", 2);
        check("start in run sum",  64'(sum),  64'(32'h0000_0100));
        check("start in run cout", 64'(cout), 64'(0));
        check("busy in done",      64'(busy), 64'(1));
        @(negedge clk);
        check("start in run done one cycle", 64'(done), 64'(0));

        // Reset during the second RUN cycle discards the operation.
        start_op(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset busy", 64'(busy), 64'(0));
        check("mid reset sum",  64'(sum),  64'(0));
        check("mid reset done", 64'(done), 64'(0));
        n_done = 0;
        repeat (NB + 2) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("mid reset no done", 64'(n_done), 64'(0));
        run_op("after reset", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

        // Start held high is re-accepted on the first IDLE cycle: two results in 12 cycles.
        @(negedge clk);
        op_a   = 32'h0000_0010;
        op_b   = 32'h0000_0020;
        cin_in = 1'b0;
        sub    = 1'b0;
        start  = 1'b1;
        n_done = 0;
        repeat (2 * (NB + 2)) begin
            @(negedge clk);
            if (done) n_done++;
        end
        start = 1'b0;
        check("held start dones", 64'(n_done), 64'(2));
        repeat (NB + 3) @(negedge clk);
        check("held start sum", 64'(sum), 64'(32'h0000_0030));

`ifdef SUB_MODE_EN
        run_op("sub borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
